spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised full-duplex SPI master; successor of the fixed 16-bit write-only spi_16b.
//  Adds configurable word width, SCK divider, CPOL/CPHA mode, bit order, MISO capture and a valid/ready request port.
//  Sits between on-chip controllers (display/peripheral drivers) and external SPI slaves.
// PARAMETERS
//  DATA_W     16  bits per frame (>=2)
//  CLK_DIV    4   clk cycles per SCK half-period (>=1)
//  CPOL       0   SCK idle level
//  CPHA       0   0: sample on leading edge, 1: sample on trailing edge
//  MSB_FIRST  1   1: MSB shifted first, 0: LSB first
//  CS_GAP     2   min clk cycles SPI_CS stays high between frames (>=1)
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  rst_n         in   1       asynchronous active-low reset
//  tx_valid      in   1       frame request
//  tx_ready      out  1       high only in IDLE; transfer accepted when tx_valid&&tx_ready
//  tx_data       in   DATA_W  word to send, captured on accept
//  rx_valid      out  1       1-clk pulse, rx_data valid
//  rx_data       out  DATA_W  word received on SPI_MISO, held until next rx_valid
//  spi_done      out  1       1-clk pulse, coincident with rx_valid
//  busy          out  1       high from accept until GAP ends
//  SPI_SCK       out  1       serial clock
//  SPI_CS        out  1       chip select, active low
//  SPI_MOSI      out  1       serial data out
//  SPI_MISO      in   1       serial data in
// BEHAVIOUR
//  Reset (async, also mid-frame): SPI_CS=1, SPI_SCK=CPOL, SPI_MOSI=0, tx_ready=1, busy=0, rx_valid=spi_done=0, rx_data=0, FSM=IDLE.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE : tx_ready=1; on accept latch tx_data into shift reg, go SETUP.
//   SETUP: CS low, SCK=CPOL, CLK_DIV cycles; MOSI = first bit (both modes).
//   SHIFT: 2*DATA_W half-periods of CLK_DIV cycles, SCK toggles at each half-period boundary.
//          Leading edge = transition away from CPOL. CPHA=0: sample MISO on leading, advance MOSI on trailing (not after last).
//          CPHA=1: advance MOSI on leading (first leading edge presents bit 0 of sequence, not a shift), sample on trailing.
//   HOLD : SCK=CPOL, CS low, CLK_DIV cycles; on exit CS rises, rx_data updated, rx_valid=spi_done=1 for that cycle.
//   GAP  : CS high for CS_GAP cycles, then IDLE.
//  Exactly DATA_W SCK pulses per frame; CS low for (2*DATA_W+2)*CLK_DIV cycles.
//  Accept at cycle t -> CS falls at t+1; spi_done at t+1+(2*DATA_W+2)*CLK_DIV.
//  Minimum frame period = 1+(2*DATA_W+2)*CLK_DIV+CS_GAP cycles; back-to-back requests wait in tx_valid.
//  tx_valid/tx_data changes while busy are ignored; rx_data bit order matches MSB_FIRST.
//  Divider counter is log2(CLK_DIV) wide and resets to 0 on each state entry; bit counter is clog2(2*DATA_W) wide.
//  Elaboration-time assertions: DATA_W>=2, CLK_DIV>=1, CS_GAP>=1, CPOL/CPHA in {0,1}.
// STRUCTURE
//  spi_pkg: typedef enum logic [2:0] spi_state_t {IDLE,SETUP,SHIFT,HOLD,GAP}; typedef struct {cpol,cpha} spi_mode_t.
//  Sub-module spi_clk_gen: CLK_DIV counter producing half-period tick + lead/trail edge strobes; enabled only in SETUP/SHIFT/HOLD.
//  Top: FSM, bit counter, TX/RX shift registers, output registers (SCK/CS/MOSI registered, glitch-free).
// TESTING
//  1 Mode0, DATA_W=16, CLK_DIV=4, MISO looped to MOSI, send 16'hAA00 -> 16 SCK pulses, CS low 136 clks, rx_data=16'hAA00, one spi_done pulse.
//  2 Back-to-back 16'hAA00 then 16'h0055 with tx_valid held -> second CS fall exactly CS_GAP+1 clks after first CS rise; MOSI bit streams match.
//  3 CPOL=1,CPHA=1, slave model drives 16'h1234 -> SCK idles high, rx_data=16'h1234, MOSI changes only on falling SCK.
//  4 DATA_W=8, MSB_FIRST=0, send 8'h01 -> first MOSI bit 1 then seven 0s; loopback rx_data=8'h01.
//  5 rst_n low mid-SHIFT (bit 7) -> same cycle CS=1, SCK=CPOL, MOSI=0; no spi_done; next request completes normally.
//  6 Change tx_data while busy -> transmitted word unchanged; tx_ready stays 0 until GAP ends.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and SPI mode pair.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK timing: CLK_DIV-cycle half-period tick plus leading/trailing edge strobes.
// Counter and edge phase clear whenever the generator is disabled.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic edge_en,
  output logic tick,
  output logic lead,
  output logic trail
);

  localparam int CNT_W = cnt_width(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;

  assign tick  = en && (cnt_q == CNT_W'(CLK_DIV - 1));
  // phase_q low means the next SCK edge leaves the idle level.
  assign lead  = tick && edge_en && !phase_q;
  assign trail = tick && edge_en && phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      if (tick) cnt_q <= '0;
      else      cnt_q <= cnt_q + 1'b1;
      if (lead || trail) phase_q <= ~phase_q;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with a valid/ready request port.
// SCK, CS and MOSI come straight from flops so the pins never glitch.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1,
  parameter int CS_GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_done,
  output logic              busy,
  output logic              SPI_SCK,
  output logic              SPI_CS,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO
);

  generate
    if (DATA_W < 2) begin : g_bad_data_w
      $error("spi_master_param: DATA_W must be >= 2");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("spi_master_param: CLK_DIV must be >= 1");
    end
    if (CS_GAP < 1) begin : g_bad_cs_gap
      $error("spi_master_param: CS_GAP must be >= 1");
    end
    if ((CPOL != 0 && CPOL != 1) || (CPHA != 0 && CPHA != 1)) begin : g_bad_mode
      $error("spi_master_param: CPOL and CPHA must be 0 or 1");
    end
  endgenerate

  localparam spi_mode_t MODE = '{cpol: (CPOL != 0), cpha: (CPHA != 0)};
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam int GAP_W  = cnt_width(CS_GAP);
  localparam logic [HALF_W-1:0] LAST_HALF  = HALF_W'(2 * DATA_W - 1);
  localparam logic [HALF_W-1:0] LAST_TRAIL = HALF_W'(2 * DATA_W - 2);

  spi_state_t        state_q, state_d;
  logic [HALF_W-1:0] half_q;
  logic [GAP_W-1:0]  gap_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, tx_next, rx_next;
  logic              tick, lead, trail, clk_en, edge_en;
  logic              accept, advance, sample, frame_end, gap_end;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  // Handshake: a request is taken on any clk edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so tx_valid/tx_data are ignored while busy.
  assign tx_ready = (state_q == IDLE);
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign spi_done = rx_valid;

  // SCK edges sit at the start of each SHIFT half-period; the final half stays idle.
  assign clk_en    = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign edge_en   = (state_q == SETUP) || ((state_q == SHIFT) && (half_q != LAST_HALF));
  assign frame_end = (state_q == HOLD) && tick;
  assign gap_end   = (state_q == GAP) && (gap_q == GAP_W'(CS_GAP - 1));
  assign advance   = MODE.cpha ? (lead && (state_q == SHIFT))
                               : (trail && (half_q != LAST_TRAIL));
  assign sample    = MODE.cpha ? trail : lead;

  assign tx_next = (MSB_FIRST != 0) ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_sh_q[DATA_W-1:1]};
  assign rx_next = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], SPI_MISO}
                                    : {SPI_MISO, rx_sh_q[DATA_W-1:1]};

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (clk_en),
    .edge_en (edge_en),
    .tick    (tick),
    .lead    (lead),
    .trail   (trail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tx_valid) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && (half_q == LAST_HALF)) state_d = HOLD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= '0;
      gap_q  <= '0;
    end else begin
      if (state_q != SHIFT) half_q <= '0;
      else if (tick)        half_q <= half_q + 1'b1;
      if (state_q != GAP)   gap_q <= '0;
      else                  gap_q <= gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      SPI_CS   <= 1'b1;
      SPI_SCK  <= MODE.cpol;
      SPI_MOSI <= 1'b0;
    end else begin
      rx_valid <= frame_end;
      if (accept) begin
        tx_sh_q  <= tx_data;
        SPI_MOSI <= first_bit(tx_data);
        SPI_CS   <= 1'b0;
      end else if (advance) begin
        tx_sh_q  <= tx_next;
        SPI_MOSI <= first_bit(tx_next);
      end
      if (frame_end) begin
        SPI_CS  <= 1'b1;
        rx_data <= rx_sh_q;
      end
      if (lead)       SPI_SCK <= ~MODE.cpol;
      else if (trail) SPI_SCK <= MODE.cpol;
      if (sample) rx_sh_q <= rx_next;
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three instances (mode 0 loopback, mode 3 with slave model,
// 8-bit LSB-first loopback) checked against a bit-level reference of the SPI wire protocol.
module tb_spi_master_param;

  localparam int CD       = 4;
  localparam int GAPC     = 2;
  localparam int CS_LOW16 = (2 * 16 + 2) * CD;
  localparam int CS_LOW8  = (2 * 8 + 2) * CD;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 16-bit, mode 0, MSB first, MISO looped to MOSI
  logic        tx_valid_a, tx_ready_a, rx_valid_a, done_a, busy_a, sck_a, cs_a, mosi_a, miso_a;
  logic [15:0] tx_data_a, rx_data_a;
  assign miso_a = mosi_a;
  // Instance B: 16-bit, CPOL=1 CPHA=1, MISO from slave model
  logic        tx_valid_b, tx_ready_b, rx_valid_b, done_b, busy_b, sck_b, cs_b, mosi_b;
  logic        miso_b = 1'b0;
  logic [15:0] tx_data_b, rx_data_b, slv_b;
  // Instance C: 8-bit, mode 0, LSB first, loopback
  logic        tx_valid_c, tx_ready_c, rx_valid_c, done_c, busy_c, sck_c, cs_c, mosi_c, miso_c;
  logic [7:0]  tx_data_c, rx_data_c;
  assign miso_c = mosi_c;

  spi_master_param #(.DATA_W(16), .CLK_DIV(CD), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .CS_GAP(GAPC)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_data(tx_data_a),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a), .spi_done(done_a), .busy(busy_a),
    .SPI_SCK(sck_a), .SPI_CS(cs_a), .SPI_MOSI(mosi_a), .SPI_MISO(miso_a));

  spi_master_param #(.DATA_W(16), .CLK_DIV(CD), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .CS_GAP(GAPC)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_data(tx_data_b),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .spi_done(done_b), .busy(busy_b),
    .SPI_SCK(sck_b), .SPI_CS(cs_b), .SPI_MOSI(mosi_b), .SPI_MISO(miso_b));

  spi_master_param #(.DATA_W(8), .CLK_DIV(CD), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .CS_GAP(GAPC)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .tx_data(tx_data_c),
    .rx_valid(rx_valid_c), .rx_data(rx_data_c), .spi_done(done_c), .busy(busy_c),
    .SPI_SCK(sck_c), .SPI_CS(cs_c), .SPI_MOSI(mosi_c), .SPI_MISO(miso_c));

  // Wire-level observers: act as the slave, sampling MOSI on the mode's sample edge
  logic        sck_a_p = 1'b0, cs_a_p = 1'b1, rdy_a_p = 1'b1;
  int          pulses_a = 0, cs_low_a = 0, done_cnt_a = 0, nbits_a = 0;
  int          cs_fall_a = 0, cs_rise_a = 0, done_cyc_a = 0, ready_rise_a = 0;
  logic [15:0] word_a = '0;
  logic [15:0] mosi_q_a[$], rx_q_a[$], exp_q[$];

  always @(negedge clk) begin
    if (!cs_a) cs_low_a++;
    if (!cs_a && cs_a_p) begin cs_fall_a = cyc; nbits_a = 0; word_a = '0; end
    if (cs_a && !cs_a_p) begin
      cs_rise_a = cyc;
      if (nbits_a == 16) mosi_q_a.push_back(word_a);
    end
    if (sck_a && !sck_a_p && !cs_a) begin
      pulses_a++;
      word_a = {word_a[14:0], mosi_a};
      nbits_a++;
    end
    if (rx_valid_a) begin done_cnt_a++; done_cyc_a = cyc; rx_q_a.push_back(rx_data_a); end
    if (tx_ready_a && !rdy_a_p) ready_rise_a = cyc;
    sck_a_p = sck_a; cs_a_p = cs_a; rdy_a_p = tx_ready_a;
  end

  logic        sck_b_p = 1'b1, cs_b_p = 1'b1, mosi_b_p = 1'b0;
  int          pulses_b = 0, done_cnt_b = 0, nbits_b = 0, k_b = 0, viol_b = 0;
  logic [15:0] word_b = '0, mosi_word_b = '0;

  always @(negedge clk) begin
    if (!cs_b && cs_b_p) begin nbits_b = 0; word_b = '0; k_b = 0; end
    if (cs_b && !cs_b_p && nbits_b == 16) mosi_word_b = word_b;
    if (!cs_b && !cs_b_p && (mosi_b !== mosi_b_p) && !(sck_b_p && !sck_b)) viol_b++;
    if (!sck_b && sck_b_p && !cs_b) begin
      pulses_b++;
      if (k_b < 16) miso_b = slv_b[4'(15 - k_b)];
      k_b++;
    end
    if (sck_b && !sck_b_p && !cs_b) begin word_b = {word_b[14:0], mosi_b}; nbits_b++; end
    if (rx_valid_b) done_cnt_b++;
    sck_b_p = sck_b; cs_b_p = cs_b; mosi_b_p = mosi_b;
  end

  logic       sck_c_p = 1'b0, cs_c_p = 1'b1, first_c = 1'b0;
  int         pulses_c = 0, cs_low_c = 0, done_cnt_c = 0, nbits_c = 0;
  logic [7:0] word_c = '0, mosi_word_c = '0;

  always @(negedge clk) begin
    if (!cs_c) cs_low_c++;
    if (!cs_c && cs_c_p) begin nbits_c = 0; word_c = '0; end
    if (cs_c && !cs_c_p && nbits_c == 8) mosi_word_c = word_c;
    if (sck_c && !sck_c_p && !cs_c) begin
      pulses_c++;
      if (nbits_c == 0) first_c = mosi_c;
      word_c = word_c | (8'(mosi_c) << nbits_c);
      nbits_c++;
    end
    if (rx_valid_c) done_cnt_c++;
    sck_c_p = sck_c; cs_c_p = cs_c;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready_a(output int acc);
    int n = 0;
    while (!tx_ready_a && n < 1000) begin @(negedge clk); n++; end
    acc = cyc;
    chk("accept_timeout_a", 32'(n < 1000), 32'd1);
  endtask

  task automatic send_a(input logic [15:0] w, output int acc);
    tx_data_a  = w;
    tx_valid_a = 1'b1;
    wait_ready_a(acc);
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (done_cnt_a < target && n < 2000) begin @(negedge clk); n++; end
    chk("done_timeout_a", 32'(n < 2000), 32'd1);
  endtask

  task automatic drain_a();
    logic [15:0] e;
    chk("frames_mosi_a", 32'(mosi_q_a.size()), 32'(exp_q.size()));
    chk("frames_rx_a", 32'(rx_q_a.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && mosi_q_a.size() > 0 && rx_q_a.size() > 0) begin
      e = exp_q.pop_front();
      chk("mosi_word_a", 32'(mosi_q_a.pop_front()), 32'(e));
      chk("rx_word_a", 32'(rx_q_a.pop_front()), 32'(e));
    end
    exp_q.delete(); mosi_q_a.delete(); rx_q_a.delete();
  endtask

  task automatic run_b(input logic [15:0] w, input logic [15:0] slave_word);
    int n = 0;
    int base_d = done_cnt_b, base_p = pulses_b, base_v = viol_b;
    slv_b = slave_word;
    tx_data_b = w; tx_valid_b = 1'b1;
    while (!tx_ready_b && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    tx_valid_b = 1'b0;
    n = 0;
    while (done_cnt_b == base_d && n < 2000) begin @(negedge clk); n++; end
    chk("done_timeout_b", 32'(n < 2000), 32'd1);
    repeat (4) @(negedge clk);
    chk("rx_b", 32'(rx_data_b), 32'(slave_word));
    chk("mosi_word_b", 32'(mosi_word_b), 32'(w));
    chk("pulses_b", 32'(pulses_b - base_p), 32'd16);
    chk("mosi_edge_b", 32'(viol_b - base_v), 32'd0);
    chk("sck_idle_b", 32'(sck_b), 32'd1);
  endtask

  task automatic run_c(input logic [7:0] w);
    int n = 0;
    int base_d = done_cnt_c, base_p = pulses_c, base_l = cs_low_c;
    tx_data_c = w; tx_valid_c = 1'b1;
    while (!tx_ready_c && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    tx_valid_c = 1'b0;
    n = 0;
    while (done_cnt_c == base_d && n < 2000) begin @(negedge clk); n++; end
    chk("done_timeout_c", 32'(n < 2000), 32'd1);
    repeat (4) @(negedge clk);
    chk("first_bit_c", 32'(first_c), 32'(w[0]));
    chk("mosi_word_c", 32'(mosi_word_c), 32'(w));
    chk("rx_c", 32'(rx_data_c), 32'(w));
    chk("pulses_c", 32'(pulses_c - base_p), 32'd8);
    chk("cs_low_c", 32'(cs_low_c - base_l), 32'(CS_LOW8));
  endtask

  initial begin
    int          acc, acc2, b_p, b_l, b_d, n;
    logic [15:0] w;
    logic        ready_seen;

    rst_n = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = '0;
    tx_valid_b = 1'b0; tx_data_b = '0; slv_b = '0;
    tx_valid_c = 1'b0; tx_data_c = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs", 32'(cs_a), 32'd1);
    chk("rst_sck_a", 32'(sck_a), 32'd0);
    chk("rst_sck_b", 32'(sck_b), 32'd1);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_ready", 32'(tx_ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_rx_valid", 32'({rx_valid_a, done_a}), 32'd0);
    chk("rst_rx_data", 32'(rx_data_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single mode-0 frame: pulse count, CS width, latencies, loopback
    b_p = pulses_a; b_l = cs_low_a; b_d = done_cnt_a;
    exp_q.push_back(16'hAA00);
    send_a(16'hAA00, acc);
    wait_done_a(b_d + 1);
    repeat (4) @(negedge clk);
    chk("t1_pulses", 32'(pulses_a - b_p), 32'd16);
    chk("t1_cs_low", 32'(cs_low_a - b_l), 32'(CS_LOW16));
    chk("t1_done_cnt", 32'(done_cnt_a - b_d), 32'd1);
    chk("t1_cs_fall_lat", 32'(cs_fall_a - acc), 32'd1);
    chk("t1_done_lat", 32'(done_cyc_a - acc), 32'(1 + CS_LOW16));
    chk("t1_rx", 32'(rx_data_a), 32'h0000AA00);
    drain_a();

    // Back-to-back requests with tx_valid held
    b_d = done_cnt_a;
    exp_q.push_back(16'hAA00);
    exp_q.push_back(16'h0055);
    tx_data_a = 16'hAA00; tx_valid_a = 1'b1;
    wait_ready_a(acc);
    @(negedge clk);
    tx_data_a = 16'h0055;
    wait_ready_a(acc2);
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_cs_gap", 32'(cs_fall_a - cs_rise_a), 32'(GAPC + 1));
    chk("t2_period", 32'(acc2 - acc), 32'(1 + CS_LOW16 + GAPC));
    wait_done_a(b_d + 2);
    repeat (4) @(negedge clk);
    drain_a();

    // Mode 3 with slave model
    run_b(16'($urandom), 16'h1234);
    run_b(16'($urandom), 16'($urandom));

    // 8-bit LSB first
    run_c(8'h01);
    run_c(8'($urandom));

    // Reset in the middle of SHIFT
    b_p = pulses_a;
    tx_data_a = 16'($urandom); tx_valid_a = 1'b1;
    wait_ready_a(acc);
    @(negedge clk);
    tx_valid_a = 1'b0;
    n = 0;
    while (pulses_a - b_p < 7 && n < 2000) begin @(negedge clk); n++; end
    chk("t5_reach_bit7", 32'(n < 2000), 32'd1);
    b_d = done_cnt_a;
    rst_n = 1'b0;
    #1;
    chk("t5_cs", 32'(cs_a), 32'd1);
    chk("t5_sck", 32'(sck_a), 32'd0);
    chk("t5_mosi", 32'(mosi_a), 32'd0);
    chk("t5_ready", 32'({tx_ready_a, busy_a}), 32'b10);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt_a - b_d), 32'd0);
    chk("t5_no_frame", 32'(mosi_q_a.size()), 32'd0);
    w = 16'($urandom);
    exp_q.push_back(w);
    send_a(w, acc);
    wait_done_a(b_d + 1);
    repeat (4) @(negedge clk);
    drain_a();

    // Request inputs wiggle while busy
    b_d = done_cnt_a;
    w = 16'($urandom);
    exp_q.push_back(w);
    send_a(w, acc);
    ready_seen = 1'b0;
    n = 0;
    while (done_cnt_a == b_d && n < 2000) begin
      tx_data_a  = 16'($urandom);
      tx_valid_a = 1'($urandom_range(0, 1));
      if (tx_ready_a) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    tx_valid_a = 1'b0;
    chk("t6_done_timeout", 32'(n < 2000), 32'd1);
    chk("t6_ready_while_busy", 32'(ready_seen), 32'd0);
    repeat (6) @(negedge clk);
    chk("t6_ready_after_gap", 32'(ready_rise_a - done_cyc_a), 32'(GAPC));
    drain_a();

    // Random loopback frames with random idle spacing
    b_d = done_cnt_a;
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      send_a(w, acc);
      wait_done_a(b_d + i + 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    drain_a();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
